// File: rtl/ctrl_pipe_pkg.sv
// Shared control definitions: opcodes, ALU-op encodings and the per-stage control words
// used by the main decoder, the ALU control and the datapath.
package ctrl_pipe_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LUI  = 6'd15;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b010,
    ALU_FUNCT = 3'b100,
    ALU_OR    = 3'b101,
    ALU_LUI   = 3'b111
  } aluOp_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef struct packed {
    aluOp_e  aluOp;
    logic    aluSrc;
    logic    regDst;
    logic    extSel;
    branch_e branch;
    logic    memRead;
    logic    memWrite;
    logic    regWrite;
    logic    memToReg;
  } ctrl_t;

  typedef struct packed {
    branch_e branch;
    logic    memRead;
    logic    memWrite;
    logic    regWrite;
    logic    memToReg;
  } memCtrl_t;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
  } wbCtrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage instruction inputs and per-stage control outputs of the pipeline controller.
interface ctrl_pipe_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5
);
  logic               instr_valid_i;
  logic [OP_W-1:0]    op_i;
  logic [REG_AW-1:0]  rs_i;
  logic [REG_AW-1:0]  rt_i;
  logic               flush_i;
  logic               stall_o;
  logic               ex_valid_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               ex_reg_dst_o;
  logic               ex_ext_sel_o;
  logic [1:0]         ex_branch_o;
  logic               mem_valid_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [1:0]         mem_branch_o;
  logic               wb_valid_o;
  logic               wb_reg_write_o;
  logic               wb_mem_to_reg_o;
  logic               illegal_o;

  modport master (
    output instr_valid_i, op_i, rs_i, rt_i, flush_i,
    input  stall_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_ext_sel_o,
           ex_branch_o, mem_valid_o, mem_read_o, mem_write_o, mem_branch_o,
           wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o, illegal_o
  );

  modport slave (
    input  instr_valid_i, op_i, rs_i, rt_i, flush_i,
    output stall_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_ext_sel_o,
           ex_branch_o, mem_valid_o, mem_read_o, mem_write_o, mem_branch_o,
           wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o, illegal_o
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational main decoder: opcode to control word, plus illegal and rt-usage flags.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            illegal,
  output logic            usesRt
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    usesRt  = 1'b0;
    case (op)
      OP_W'(OP_R): begin
        ctrl.aluOp    = ALU_FUNCT;
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        usesRt        = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        ctrl.aluOp  = ALU_SUB;
        ctrl.branch = BR_EQ;
        usesRt      = 1'b1;
      end
      OP_W'(OP_BNE): begin
        ctrl.aluOp  = ALU_SUB;
        ctrl.branch = BR_NE;
        usesRt      = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        ctrl.aluOp    = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_W'(OP_ORI): begin
        ctrl.aluOp    = ALU_OR;
        ctrl.aluSrc   = 1'b1;
        ctrl.extSel   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_W'(OP_LUI): begin
        ctrl.aluOp    = ALU_LUI;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_W'(OP_LW): begin
        ctrl.aluOp    = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      OP_W'(OP_SW): begin
        ctrl.aluOp    = ALU_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
        usesRt        = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline controller: ID decode, ID->EX->MEM->WB control registers, load-use stall and flush.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ctrl_pipe_if.slave bus
);

  ctrl_t             ctrl_p0;
  logic              illegal_p0;
  logic              usesRt_p0;
  logic              loadUse;
  logic              stall;
  logic              accept_p0;

  logic              vld_p1;
  ctrl_t             ctrl_p1;
  logic [REG_AW-1:0] rt_p1;
  logic              illegal_p1;
  logic              vld_p2;
  memCtrl_t          ctrl_p2;
  logic              vld_p3;
  wbCtrl_t           ctrl_p3;

  ctrl_decode #(.OP_W(OP_W)) uDecode (
    .op      (bus.op_i),
    .ctrl    (ctrl_p0),
    .illegal (illegal_p0),
    .usesRt  (usesRt_p0)
  );

  // A load in EX whose destination is read by the ID instruction must wait a cycle;
  // a flush kills the ID instruction anyway, so it never stalls.
  assign loadUse   = bus.instr_valid_i & vld_p1 & ctrl_p1.memRead & (rt_p1 != '0) &
                     ((rt_p1 == bus.rs_i) | ((rt_p1 == bus.rt_i) & usesRt_p0));
  assign stall     = loadUse & ~bus.flush_i;
  assign accept_p0 = bus.instr_valid_i & ~stall & ~bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= CTRL_NOP;
      rt_p1      <= '0;
      illegal_p1 <= 1'b0;
      vld_p2     <= 1'b0;
      ctrl_p2    <= '0;
      vld_p3     <= 1'b0;
      ctrl_p3    <= '0;
    end else begin
      // ID -> EX
      vld_p1     <= accept_p0;
      ctrl_p1    <= accept_p0 ? ctrl_p0 : CTRL_NOP;
      rt_p1      <= accept_p0 ? bus.rt_i : '0;
      illegal_p1 <= accept_p0 & illegal_p0;
      // EX -> MEM
      vld_p2 <= vld_p1 & ~bus.flush_i;
      if (bus.flush_i) begin
        ctrl_p2 <= '0;
      end else begin
        ctrl_p2 <= '{branch:   ctrl_p1.branch,
                     memRead:  ctrl_p1.memRead,
                     memWrite: ctrl_p1.memWrite,
                     regWrite: ctrl_p1.regWrite,
                     memToReg: ctrl_p1.memToReg};
      end
      // MEM -> WB
      vld_p3  <= vld_p2;
      ctrl_p3 <= '{regWrite: ctrl_p2.regWrite, memToReg: ctrl_p2.memToReg};
    end
  end

  assign bus.stall_o         = stall;
  assign bus.illegal_o       = vld_p1 & illegal_p1;
  assign bus.ex_valid_o      = vld_p1;
  assign bus.ex_alu_op_o     = vld_p1 ? ALUOP_W'(ctrl_p1.aluOp) : '0;
  assign bus.ex_alu_src_o    = vld_p1 & ctrl_p1.aluSrc;
  assign bus.ex_reg_dst_o    = vld_p1 & ctrl_p1.regDst;
  assign bus.ex_ext_sel_o    = vld_p1 & ctrl_p1.extSel;
  assign bus.ex_branch_o     = vld_p1 ? 2'(ctrl_p1.branch) : 2'b00;
  assign bus.mem_valid_o     = vld_p2;
  assign bus.mem_read_o      = vld_p2 & ctrl_p2.memRead;
  assign bus.mem_write_o     = vld_p2 & ctrl_p2.memWrite;
  assign bus.mem_branch_o    = vld_p2 ? 2'(ctrl_p2.branch) : 2'b00;
  assign bus.wb_valid_o      = vld_p3;
  assign bus.wb_reg_write_o  = vld_p3 & ctrl_p3.regWrite;
  assign bus.wb_mem_to_reg_o = vld_p3 & ctrl_p3.memToReg;

endmodule
